// File: rtl/mul32_seq_pkg.sv
// Shared p32m2 multiplier definitions: operand width, counter width and the
// controller state encoding.
package mul32_seq_pkg;

  localparam int W     = 32;
  localparam int CNT_W = $clog2(W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mul32_seq_if.sv
// Request/response bundle of the sequential multiplier. The requester drives
// start and the operands; the multiplier returns busy, done and the product.
interface mul32_seq_if #(
  parameter int W = mul32_seq_pkg::W
);

  logic           start;
  logic [W-1:0]   mcand;
  logic [W-1:0]   mplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] prod;

  modport master (
    output start, mcand, mplier,
    input  busy, done, prod
  );

  modport slave (
    input  start, mcand, mplier,
    output busy, done, prod
  );

endinterface

// File: rtl/mul32_seq.sv
// Sequential unsigned W x W -> 2W shift-and-add multiplier. It has no adder of
// its own: each RUN cycle it presents P_hi and the gated multiplicand to the
// shared ripple adder and shifts {cout, sum, P_lo} right by one bit.
module mul32_seq
  import mul32_seq_pkg::*;
#(
  parameter int W = mul32_seq_pkg::W
) (
  input  logic         m_clock,
  input  logic         p_reset,
  mul32_seq_if.slave   mul,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic         add_cin,
  output logic         add_en,
  input  logic [W-1:0] add_sum,
  input  logic         add_cout
);

  state_t             state_reg;
  logic [W-1:0]       mcand_reg;
  logic [W-1:0]       p_hi_reg;
  logic [W-1:0]       p_lo_reg;
  logic [CNT_W-1:0]   cnt_reg;

  // All status and adder-side outputs decode straight from registers, so they
  // carry no combinational path from the requester inputs.
  assign mul.busy = (state_reg == ST_RUN);
  assign mul.done = (state_reg == ST_DONE);
  assign mul.prod = {p_hi_reg, p_lo_reg};

  assign add_a   = p_hi_reg;
  assign add_b   = p_lo_reg[0] ? mcand_reg : '0;
  assign add_cin = 1'b0;
  assign add_en  = (state_reg == ST_RUN);

  // Controller and datapath: accept in IDLE/DONE, one product bit per RUN cycle.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state_reg <= ST_IDLE;
      mcand_reg <= '0;
      p_hi_reg  <= '0;
      p_lo_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          // The carry-out becomes the new top bit; dropping P_lo[0] is the
          // right shift that retires one multiplier bit.
          p_hi_reg <= {add_cout, add_sum[W-1:1]};
          p_lo_reg <= {add_sum[0], p_lo_reg[W-1:1]};
          cnt_reg  <= cnt_reg - 1'b1;
          if (cnt_reg == '0) begin
            state_reg <= ST_DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; DONE lasts one cycle.
          if (mul.start) begin
            mcand_reg <= mul.mcand;
            p_hi_reg  <= '0;
            cnt_reg   <= CNT_W'(W - 1);
            if ((mul.mcand == '0) || (mul.mplier == '0)) begin
              // A zero operand gives a zero product without iterating.
              p_lo_reg  <= '0;
              state_reg <= ST_DONE;
            end else begin
              p_lo_reg  <= mul.mplier;
              state_reg <= ST_RUN;
            end
          end else begin
            state_reg <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul32_seq.sv
// Self-checking bench for mul32_seq with a behavioural add32 and a plain
// arithmetic reference product.
module tb_mul32_seq;

  localparam int W = 32;

  logic m_clock = 1'b0;
  logic p_reset = 1'b0;

  always #5 m_clock = ~m_clock;

  mul32_seq_if #(.W(W)) mif ();

  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic [W-1:0] add_sum;
  logic         add_cin;
  logic         add_en;
  logic         add_cout;

  // Behavioural add32 attached to the adder port.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  mul32_seq #(.W(W)) dut (
    .m_clock  (m_clock),
    .p_reset  (p_reset),
    .mul      (mif),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_en   (add_en),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Results captured by wait_done for the latest operation.
  int          r_done_n;
  int          r_busy_n;
  bit          r_en;
  bit          r_cin_bad;
  logic [63:0] r_prod;
  logic [63:0] r_prod1;
  logic [31:0] r_adda1;
  logic [31:0] r_addb1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    return {32'h0, a} * {32'h0, b};
  endfunction

  // Present a request for one clock edge, then scramble the operand inputs.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    mif.start  = 1'b1;
    mif.mcand  = a;
    mif.mplier = b;
    @(posedge m_clock);
    #1;
    mif.start  = 1'b0;
    mif.mcand  = $urandom;
    mif.mplier = $urandom;
  endtask

  // Observe each cycle after the accept edge until done (bounded to 40 cycles).
  // pulse_at > 0 injects a 7 x 7 start request in that cycle.
  task automatic wait_done(input int pulse_at);
    bit fin;
    int n;
    fin       = 1'b0;
    n         = 0;
    r_done_n  = 0;
    r_busy_n  = 0;
    r_en      = 1'b0;
    r_cin_bad = 1'b0;
    r_prod    = '0;
    while (!fin && n < 40) begin
      @(negedge m_clock);
      n++;
      if (n == pulse_at) begin
        mif.start  = 1'b1;
        mif.mcand  = 32'd7;
        mif.mplier = 32'd7;
      end
      if (pulse_at > 0 && n == pulse_at + 1) mif.start = 1'b0;
      if (mif.busy) r_busy_n++;
      if (add_en) r_en = 1'b1;
      if (add_cin) r_cin_bad = 1'b1;
      if (n == 1) begin
        r_prod1 = mif.prod;
        r_adda1 = add_a;
        r_addb1 = add_b;
      end
      if (mif.done) begin
        r_done_n = n;
        r_prod   = mif.prod;
        fin      = 1'b1;
      end
    end
  endtask

  // One full multiply with all timing and value checks. chain=1 leaves the
  // bench sitting in the done cycle so the caller can issue a back-to-back start.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int pulse_at, input bit chain);
    bit zero_op;
    zero_op = (a == 32'h0) || (b == 32'h0);
    launch(a, b);
    wait_done(pulse_at);
    check_eq({tag, " prod"}, r_prod, ref_mul(a, b));
    check_eq({tag, " cin"}, 64'(r_cin_bad), 64'd0);
    if (zero_op) begin
      check_eq({tag, " latency"}, 64'(r_done_n), 64'd1);
      check_eq({tag, " busy cycles"}, 64'(r_busy_n), 64'd0);
      check_eq({tag, " add_en seen"}, 64'(r_en), 64'd0);
    end else begin
      check_eq({tag, " latency"}, 64'(r_done_n), 64'd33);
      check_eq({tag, " busy cycles"}, 64'(r_busy_n), 64'd32);
      check_eq({tag, " add_en seen"}, 64'(r_en), 64'd1);
      check_eq({tag, " loaded prod"}, r_prod1, {32'h0, b});
      check_eq({tag, " first add_a"}, 64'(r_adda1), 64'd0);
      check_eq({tag, " first add_b"}, 64'(r_addb1), 64'(b[0] ? a : 32'h0));
    end
    if (!chain) begin
      @(negedge m_clock);
      check_eq({tag, " done pulse"}, 64'(mif.done), 64'd0);
    end
    $display("mul %s: 0x%h x 0x%h -> 0x%h in %0d cycles", tag, a, b, r_prod, r_done_n);
  endtask

  initial begin
    bit          saw;
    logic [31:0] ra;
    logic [31:0] rb;

    mif.start  = 1'b0;
    mif.mcand  = '0;
    mif.mplier = '0;
    p_reset    = 1'b0;
    #12;
    check_eq("reset busy", 64'(mif.busy), 64'd0);
    check_eq("reset done", 64'(mif.done), 64'd0);
    check_eq("reset prod", mif.prod, 64'd0);
    check_eq("reset add_en", 64'(add_en), 64'd0);
    check_eq("reset add_a", 64'(add_a), 64'd0);
    check_eq("reset add_b", 64'(add_b), 64'd0);
    check_eq("reset add_cin", 64'(add_cin), 64'd0);
    @(negedge m_clock);
    p_reset = 1'b1;
    @(negedge m_clock);

    run_mul("3x5", 32'd3, 32'd5, 0, 1'b0);
    check_eq("3x5 const", r_prod, 64'h0000_0000_0000_000F);
    run_mul("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    check_eq("ffxff const", r_prod, 64'hFFFF_FFFE_0000_0001);
    run_mul("zero mcand", 32'h0, 32'h1234_5678, 0, 1'b0);
    run_mul("zero mplier", 32'h8000_0000, 32'h0, 0, 1'b0);

    // A start during RUN must be ignored.
    run_mul("ignore", 32'h0001_0000, 32'h0001_0000, 10, 1'b0);
    check_eq("ignore const", r_prod, 64'h0000_0001_0000_0000);

    // Asynchronous reset in the middle of a multiply.
    launch(32'h1234_5678, 32'h9ABC_DEF1);
    repeat (14) @(negedge m_clock);
    #2;
    p_reset = 1'b0;
    #1;
    check_eq("abort busy", 64'(mif.busy), 64'd0);
    check_eq("abort done", 64'(mif.done), 64'd0);
    check_eq("abort prod", mif.prod, 64'd0);
    check_eq("abort add_en", 64'(add_en), 64'd0);
    check_eq("abort add_a", 64'(add_a), 64'd0);
    check_eq("abort add_b", 64'(add_b), 64'd0);
    saw = 1'b0;
    repeat (5) begin
      @(negedge m_clock);
      if (mif.done || mif.busy) saw = 1'b1;
    end
    check_eq("abort quiet", 64'(saw), 64'd0);
    p_reset = 1'b1;
    @(negedge m_clock);
    run_mul("2x3", 32'd2, 32'd3, 0, 1'b0);

    // Back-to-back: new start issued in the done cycle.
    run_mul("6x7", 32'd6, 32'd7, 0, 1'b1);
    run_mul("9x9", 32'd9, 32'd9, 0, 1'b0);

    // Randomised operands, with some forced top bits and an occasional zero.
    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 1) ra = ra | 32'h8000_0000;
      if (i % 4 == 2) rb = rb | 32'hC000_0000;
      if (i == 7) rb = 32'h0;
      run_mul($sformatf("rand%0d", i), ra, rb, 0, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
